// File: rtl/slice_sched_pkg.sv
// Shared types and constants for the slice scheduler.
package slice_sched_pkg;

  localparam int unsigned PERIOD_WIDTH_DEF = 24;
  localparam int unsigned SLICE_LOG_DEF    = 6;
  localparam int unsigned FRAME_WIDTH_DEF  = 8;
  localparam int unsigned MIN_PERIOD_DEF   = 1024;

  // Slices per revolution at the default slice resolution
  localparam int unsigned SLICES = 1 << SLICE_LOG_DEF;

  // Dropped-slice counter width and its saturation value
  localparam int unsigned OVERRUN_WIDTH = 16;
  localparam logic [OVERRUN_WIDTH-1:0] OVERRUN_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    RUN
  } state_t;

endpackage

// File: rtl/slice_scheduler_period_meter.sv
// Rotation-sync edge detect and saturating revolution period counter.
module period_meter
  import slice_sched_pkg::*;
#(
  parameter int unsigned PERIOD_WIDTH = PERIOD_WIDTH_DEF,
  parameter int unsigned MIN_PERIOD   = MIN_PERIOD_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    rev_sync,
  output logic                    rise_c,
  output logic                    valid_c,
  output logic                    sat_c,
  output logic [PERIOD_WIDTH-1:0] period_c
);

  localparam logic [PERIOD_WIDTH-1:0] PERIOD_MAX = '1;
  localparam logic [PERIOD_WIDTH-1:0] MIN_P      = PERIOD_WIDTH'(MIN_PERIOD);

  logic                    rev_sync_q;
  logic [PERIOD_WIDTH-1:0] count;

  assign rise_c   = rev_sync & ~rev_sync_q;
  assign sat_c    = (count == PERIOD_MAX);
  assign valid_c  = (count >= MIN_P) && !sat_c;
  assign period_c = count;

  // Register sync level; count clocks since the last rise, holding at all-ones
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rev_sync_q <= 1'b0;
      count      <= '0;
    end else begin
      rev_sync_q <= rev_sync;
      if (rise_c) begin
        count <= PERIOD_WIDTH'(1);
      end else if (!sat_c) begin
        count <= count + PERIOD_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/slice_scheduler.sv
// Volumetric slice playback sequencer: splits each revolution into equal
// slices and requests one frame per slice from the frame reader.
// Optional build macro SLICE_SCHED_OVERRUN_CNT_EN adds overrun_cnt.
module slice_scheduler
  import slice_sched_pkg::*;
#(
  parameter int unsigned PERIOD_WIDTH = PERIOD_WIDTH_DEF,
  parameter int unsigned SLICE_LOG    = SLICE_LOG_DEF,
  parameter int unsigned FRAME_WIDTH  = FRAME_WIDTH_DEF,
  parameter int unsigned MIN_PERIOD   = MIN_PERIOD_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rev_sync,
  input  logic                   anim_next,
  input  logic                   rd_ack,
  output logic                   rd_req,
  output logic [FRAME_WIDTH-1:0] frame_num,
  output logic                   locked,
  output logic                   blank
`ifdef SLICE_SCHED_OVERRUN_CNT_EN
  ,
  output logic [OVERRUN_WIDTH-1:0] overrun_cnt
`endif
);

  localparam int unsigned PAGE_WIDTH = FRAME_WIDTH - SLICE_LOG;
  localparam logic [SLICE_LOG-1:0] LAST_SLICE = '1;

  state_t                  state;
  logic [PERIOD_WIDTH-1:0] slice_len;
  logic [PERIOD_WIDTH-1:0] slice_timer;
  logic [SLICE_LOG-1:0]    slice_idx;
  logic [PAGE_WIDTH-1:0]   page;
  logic                    anim_pend;

  logic                    rise_c;
  logic                    valid_c;
  logic                    sat_c;
  logic [PERIOD_WIDTH-1:0] period_c;
  logic                    valid_rise_c;
  logic                    enter_idle_c;
  logic                    expire_c;
  logic                    issue_c;
  logic                    pending_c;
  logic [SLICE_LOG-1:0]    issue_idx_c;
  logic [PAGE_WIDTH-1:0]   page_next_c;

  period_meter #(
    .PERIOD_WIDTH(PERIOD_WIDTH),
    .MIN_PERIOD  (MIN_PERIOD)
  ) u_period_meter (
    .clock   (clock),
    .reset   (reset),
    .rev_sync(rev_sync),
    .rise_c  (rise_c),
    .valid_c (valid_c),
    .sat_c   (sat_c),
    .period_c(period_c)
  );

  // Slice issue decision, page advance and handshake status for this cycle
  always_comb begin
    valid_rise_c = rise_c && valid_c;
    enter_idle_c = 1'b0;
    expire_c     = 1'b0;
    issue_c      = 1'b0;
    issue_idx_c  = slice_idx;
    page_next_c  = page;
    pending_c    = rd_req && !rd_ack;
    if (state == SYNC && rise_c && !valid_c) begin
      enter_idle_c = 1'b1;
    end
    if (state == RUN) begin
      enter_idle_c = rise_c ? !valid_c : sat_c;
      expire_c     = !rise_c && (slice_timer == slice_len - PERIOD_WIDTH'(1));
      if (valid_rise_c && anim_pend) begin
        page_next_c = page + PAGE_WIDTH'(1);
      end
    end
    if ((state == SYNC || state == RUN) && valid_rise_c) begin
      issue_c     = 1'b1;
      issue_idx_c = '0;
    end else if (expire_c && slice_idx != LAST_SLICE) begin
      issue_c     = 1'b1;
      issue_idx_c = slice_idx + SLICE_LOG'(1);
    end
  end

  // Playback state machine, slice timing, page latch and request handshake
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      slice_len   <= '0;
      slice_timer <= '0;
      slice_idx   <= '0;
      page        <= '0;
      anim_pend   <= 1'b0;
      rd_req      <= 1'b0;
      frame_num   <= '0;
      locked      <= 1'b0;
      blank       <= 1'b1;
    end else begin
      case (state)
        IDLE: if (rise_c) state <= SYNC;
        SYNC: begin
          if (enter_idle_c) begin
            state <= IDLE;
          end else if (valid_rise_c) begin
            state  <= RUN;
            locked <= 1'b1;
            blank  <= 1'b0;
          end
        end
        RUN: begin
          if (enter_idle_c) begin
            state  <= IDLE;
            locked <= 1'b0;
            blank  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (valid_rise_c && state != IDLE) begin
        slice_len   <= period_c >> SLICE_LOG;
        slice_timer <= '0;
        slice_idx   <= '0;
      end else if (state == RUN) begin
        if (expire_c) begin
          slice_timer <= '0;
          slice_idx   <= issue_idx_c;
        end else begin
          slice_timer <= slice_timer + PERIOD_WIDTH'(1);
        end
      end

      if (state == RUN && valid_rise_c) begin
        page      <= page_next_c;
        anim_pend <= anim_next;
      end else if (anim_next) begin
        anim_pend <= 1'b1;
      end

      // A request still awaiting its ack swallows the new slice
      if (issue_c && !pending_c) begin
        rd_req    <= 1'b1;
        frame_num <= {page_next_c, issue_idx_c};
      end else if (rd_req && rd_ack) begin
        rd_req <= 1'b0;
      end
    end
  end

`ifdef SLICE_SCHED_OVERRUN_CNT_EN
  // Saturating count of dropped slices since the last loss of lock
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overrun_cnt <= '0;
    end else if (enter_idle_c) begin
      overrun_cnt <= '0;
    end else if (issue_c && pending_c && overrun_cnt != OVERRUN_MAX) begin
      overrun_cnt <= overrun_cnt + OVERRUN_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_slice_scheduler.sv
// Self-checking bench for slice_scheduler (PERIOD_WIDTH reduced to 14 so
// counter saturation is reachable in a short run).
module tb_slice_scheduler;

  localparam int PW     = 14;
  localparam int SL     = 6;
  localparam int FW     = 8;
  localparam int MINP   = 1024;
  localparam int PMAX   = (1 << PW) - 1;
  localparam int NSL    = 1 << SL;
  localparam int NPAGES = 1 << (FW - SL);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rev_sync = 1'b0;
  logic          anim_next = 1'b0;
  logic          rd_ack = 1'b1;
  logic          rd_req;
  logic [FW-1:0] frame_num;
  logic          locked;
  logic          blank;
`ifdef SLICE_SCHED_OVERRUN_CNT_EN
  logic [15:0]   overrun_cnt;
`endif

  slice_scheduler #(
    .PERIOD_WIDTH(PW),
    .SLICE_LOG   (SL),
    .FRAME_WIDTH (FW),
    .MIN_PERIOD  (MINP)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .rev_sync (rev_sync),
    .anim_next(anim_next),
    .rd_ack   (rd_ack),
    .rd_req   (rd_req),
    .frame_num(frame_num),
    .locked   (locked),
    .blank    (blank)
`ifdef SLICE_SCHED_OVERRUN_CNT_EN
    ,
    .overrun_cnt(overrun_cnt)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int cyc;
    int frame;
  } ev_t;
  ev_t exp_q[$];
  ev_t act_q[$];

  // Log every newly issued request (cycle of issue, frame number)
  bit prev_pend = 1'b0;
  always @(negedge clock) begin
    ev_t e;
    if (!reset && rd_req && !prev_pend) begin
      e.cyc   = cyc;
      e.frame = int'(frame_num);
      act_q.push_back(e);
    end
    prev_pend = !reset && rd_req && !rd_ack;
  end

  // Reference model: playback mode and the requests each revolution should produce
  int m_mode  = 0;  // 0 idle, 1 one period seen, 2 running
  int m_rprev = 0;
  int m_len   = 0;
  int m_page  = 0;
  bit m_pend  = 1'b0;
  int m_drop  = -1;

  function automatic void push_exp(input int c, input int f);
    ev_t e;
    e.cyc   = c;
    e.frame = f;
    exp_q.push_back(e);
  endfunction

  function automatic void close_rev(input int end_cyc);
    for (int k = 1; k < NSL; k++)
      if (m_rprev + k * m_len < end_cyc && k != m_drop)
        push_exp(m_rprev + k * m_len, m_page * NSL + k);
    m_drop = -1;
  endfunction

  function automatic void start_rev(input int r, input int p);
    m_len = p / NSL;
    push_exp(r, m_page * NSL);
  endfunction

  function automatic void model_rise(input int r, input bit coinc);
    int p;
    bit valid;
    p = r - m_rprev;
    valid = (p >= MINP) && (p < PMAX);
    case (m_mode)
      0: m_mode = 1;
      1: if (valid) begin m_mode = 2; start_rev(r, p); end else m_mode = 0;
      default: begin
        close_rev(r);
        if (valid) begin
          if (m_pend) begin m_page = (m_page + 1) % NPAGES; m_pend = 1'b0; end
          start_rev(r, p);
        end else m_mode = 0;
      end
    endcase
    if (coinc) m_pend = 1'b1;
    m_rprev = r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic compare_q(input string tag);
    chk({tag, "_count"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      chk({tag, "_cyc"}, act_q[i].cyc, exp_q[i].cyc);
      chk({tag, "_frame"}, act_q[i].frame, exp_q[i].frame);
    end
    exp_q.delete();
    act_q.delete();
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Rising sync edge (seen by the DUT on the next clock), optional coincident anim pulse
  task automatic rise(input bit coinc);
    rev_sync  = 1'b1;
    anim_next = coinc;
    model_rise(cyc + 1, coinc);
    step(1);
    anim_next = 1'b0;
  endtask

  // Remainder of a p-clock revolution, optionally with a mid-revolution anim pulse
  task automatic tail(input int p, input bit mid);
    step(9);
    rev_sync = 1'b0;
    if (mid) begin
      step(p / 2 - 10);
      anim_next = 1'b1;
      m_pend    = 1'b1;
      step(1);
      anim_next = 1'b0;
      step(p - p / 2 - 1);
    end else begin
      step(p - 10);
    end
  endtask

  initial begin
    int p1, p2, r;

    // Reset values
    step(3);
    chk("rst_req", rd_req, 0);
    chk("rst_frame", frame_num, 0);
    chk("rst_locked", locked, 0);
    chk("rst_blank", blank, 1);
    reset = 1'b0;
    step(2);

    // Lock, steady playback, page advance, random periods, short-period drop-out
    p1 = $urandom_range(6000, 1100);
    p2 = $urandom_range(6000, 1100);
    rise(0);
    tail(4096, 0);
    chk("sync_locked", locked, 0);
    chk("sync_blank", blank, 1);
    rise(0);
    chk("lock_locked", locked, 1);
    chk("lock_blank", blank, 0);
    tail(4096, 1);
    rise(0);
    tail(4096, 0);
    rise(1);
    tail(p1, 0);
    rise(0);
    tail(p2, 0);
    rise(0);
    tail(500, 0);
    chk("pre_short_blank", blank, 0);
    rise(0);
    chk("short_blank", blank, 1);
    chk("short_locked", locked, 0);
    tail(2000, 0);
    compare_q("play");

    // Counter saturation while running
    rise(0);
    tail(4096, 0);
    rise(0);
    r = m_rprev;
    step(9);
    rev_sync = 1'b0;
    step(PMAX - 10);
    chk("pre_sat_blank", blank, 0);
    chk("pre_sat_locked", locked, 1);
    step(1);
    chk("sat_blank", blank, 1);
    chk("sat_locked", locked, 0);
    close_rev(r + PMAX);
    m_mode = 0;
    step(5);
    compare_q("sat");

    // Slow ack causes one dropped slice
    rise(0);
    tail(4096, 0);
    rise(0);
    step(9);
    rev_sync = 1'b0;
    step(311);
    rd_ack = 1'b0;
    chk("ovr_req", rd_req, 1);
    chk("ovr_frame", frame_num, m_page * NSL + 5);
    step(70);
    m_drop = 6;
    chk("ovr_req_hold", rd_req, 1);
    chk("ovr_frame_hold", frame_num, m_page * NSL + 5);
    step(29);
    rd_ack = 1'b1;
    step(1);
    chk("ovr_req_done", rd_req, 0);
`ifdef SLICE_SCHED_OVERRUN_CNT_EN
    chk("ovr_cnt", overrun_cnt, 1);
`endif
    step(3675);
    rise(0);
    tail(600, 0);
    rise(0);
    tail(100, 0);
    compare_q("ovr");
`ifdef SLICE_SCHED_OVERRUN_CNT_EN
    chk("ovr_cnt_idle", overrun_cnt, 0);
`endif

    // Asynchronous reset while a request is outstanding
    rise(0);
    tail(4096, 0);
    rd_ack = 1'b0;
    rise(0);
    chk("pre_areset_req", rd_req, 1);
    chk("pre_areset_locked", locked, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("areset_req", rd_req, 0);
    chk("areset_blank", blank, 1);
    chk("areset_locked", locked, 0);
    chk("areset_frame", frame_num, 0);
    rev_sync = 1'b0;
    step(2);
    exp_q.delete();
    act_q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/slice_scheduler.md
Name: slice_scheduler

Overview:
Sequences volumetric slice playback on the 16x16 rotating display. Measures the revolution period from the stabilised rotation-sync level and divides each revolution into 2^SLICE_LOG equal time slices. For each slice it requests the matching frame from the frame reader over a req/ack handshake, and blanks the matrix while rotation is not locked. Sits between the signal stabilizer output and the frame_reader/disp_matrix pair.

Parameters:
PERIOD_WIDTH, 24, width of the revolution period counter in clocks
SLICE_LOG, 6, log2 of the number of slices per revolution
FRAME_WIDTH, 8, width of frame_num; must be greater than SLICE_LOG
MIN_PERIOD, 1024, shortest valid revolution in clocks

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
rev_sync  in  1  stabilised rotation sync level; a rising edge marks the revolution start
anim_next  in  1  one-cycle pulse that advances the animation page at the next revolution start
rd_ack  in  1  frame reader accepts the current request
rd_req  out  1  frame request
frame_num  out  FRAME_WIDTH  {page, slice_idx}, with page = FRAME_WIDTH-SLICE_LOG bits
locked  out  1  rotation period valid, playback running
blank  out  1  gates point_enable; high means dark

Behaviour:
- Reset (async, active-high): state IDLE; rd_req=0, frame_num=0, locked=0, blank=1; all counters, page and the anim_next latch are 0.
- Edge detect: rev_sync is registered once; rise = rev_sync & ~rev_sync_q. The rise acts one cycle after the input changes.
- Period counter: increments every clock, saturates at all-ones, and clears to 1 on rise.
- Valid period: at rise, the counter is >= MIN_PERIOD and not saturated.
- slice_len = period >> SLICE_LOG. It is latched at each valid rise and is never 0, because MIN_PERIOD >= 2^SLICE_LOG.
- State machine:
  - IDLE: waits for rise, then moves to SYNC. Not locked, blank=1.
  - SYNC: one period has been measured. On a valid rise, latch slice_len and go to RUN with slice_idx=0, and issue a request. On an invalid rise, go to IDLE.
  - RUN: locked=1, blank=0.
    - The slice timer counts up to slice_len-1. At expiry, slice_idx increments and a request is issued.
    - slice_idx stops at 2^SLICE_LOG-1; it does not wrap without a rise.
    - On a valid rise: relatch slice_len, set slice_idx to 0, clear the slice timer, and issue a request.
    - On an invalid rise or counter saturation: go to IDLE. locked and blank change in the same cycle.
- Handshake:
  - Issuing a request sets rd_req=1 and loads frame_num.
  - frame_num is stable while rd_req=1 && !rd_ack.
  - The transfer completes in a cycle where rd_req && rd_ack. rd_req falls next cycle unless a new request is issued in that same cycle; in that case it stays 1 with the new frame_num.
  - rd_ack while rd_req=0 is ignored.
- Overrun: a new request while one is still pending (no ack yet) does not change frame_num. That slice is dropped; the next issue after the ack uses the current slice_idx.
- Entering IDLE does not cancel a pending rd_req; it completes on ack. No new requests are issued in IDLE or SYNC.
- Page: an anim_next pulse sets a latch. At the next valid rise in RUN, page increments (wrapping) and the latch clears. A pulse in the same cycle as that rise applies at the following rise.
- Simultaneous events: rise beats slice expiry. Reset beats everything.

Optional Feature:
- Macro: SLICE_SCHED_OVERRUN_CNT_EN.
- When defined, adds output overrun_cnt [15:0]: increments, saturating, on each dropped-slice event; clears on reset and on IDLE entry.
- When undefined, the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package slice_sched_pkg holds:
  - state enum: IDLE, SYNC, RUN;
  - the localparam SLICES = 1<<SLICE_LOG;
  - the saturation-max helper constant.
- One natural sub-module, period_meter: the edge detect, the saturating period counter and the valid/saturated flags.

Test Plan:
- Reset mid-RUN with rd_req=1 -> all outputs go to reset values asynchronously: rd_req=0, blank=1, locked=0.
- rev_sync rises every 4096 clocks with SLICE_LOG=6 and rd_ack tied high -> locked after the 2nd rise. 64 requests per revolution spaced 64 clocks apart, frame_num 0..63.
- Rise intervals 4096 then 500 -> lock on the 2nd rise. On the 500-clock rise, go to IDLE and blank=1 on the next cycle.
- rev_sync held low for 2^24 clocks while in RUN -> saturation forces IDLE and blank=1.
- rd_ack delayed 100 clocks with slice_len=64 -> frame_num stays constant until the ack and the dropped slice is skipped. Macro build: overrun_cnt=1.
- anim_next pulse mid-revolution with FRAME_WIDTH=8 -> the next revolution's frame_num runs 64..127. A pulse coincident with that rise -> the page increments one revolution later.
